luhnmod16_gen: RTL and testbench
================================

# luhnmod16_gen

Luhn mod-16 check-nibble generator: the transmit-side counterpart of the team's Luhn mod-16 checker. Accepts a payload size and a stream of payload nibbles, forwards every payload nibble unchanged to its output stream, then appends one computed check nibble. Any conforming checker therefore reports the resulting message as valid. It sits in front of the channel or FIFO that feeds the checker, and all three streams use valid/ready handshakes.

## Interface
Parameters:
- SIZE_W, 8, width of the payload-size field (payload 0..2^SIZE_W-1 nibbles)

Ports:
- clock  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- size_valid  in  1  size word offered
- size_ready  out  1  generator accepts a size word
- size  in  SIZE_W  payload length P in nibbles (excludes the check nibble)
- data_valid  in  1  payload nibble offered
- data_ready  out  1  generator accepts a payload nibble
- data  in  4  payload nibble, first-transmitted first
- out_valid  out  1  output nibble valid
- out_ready  in  1  downstream accepts the output nibble
- out_data  out  4  payload nibble or check nibble
- out_last  out  1  high only with the check nibble (end of message)

## Operation
- Handshake on any stream: a transfer occurs on a rising edge where valid && ready.
- State machine with three states: IDLE, DATA, CHECK.
  - IDLE: size_ready=1, data_ready=0. On a size transfer: rem<=size, accum<=0. Next state is DATA if size!=0, else CHECK.
  - DATA: size_ready=0, data_ready = (!out_valid || out_ready). On a data transfer:
    - out_data<=data, out_valid<=1, out_last<=0.
    - accum<=accum+f(data), rem<=rem-1.
    - When rem==1 at the transfer, go to CHECK.
  - CHECK: size_ready=0, data_ready=0. When (!out_valid || out_ready):
    - out_data<=(16-accum) mod 16, i.e. 4-bit two's-complement negate.
    - out_valid<=1, out_last<=1.
    - Go to IDLE.
- Weighting: rem is the count of payload nibbles remaining, including the current one, P down to 1.
  - rem odd: f(d) = hi(2d) + lo(2d), with 2d a 5-bit value, i.e. bit4 + bits[3:0].
  - rem even: f(d) = d.
- accum is 4 bits and wraps mod 16. f(d) is at most 15, so 5 bits suffice before truncation.
- Output register: out_valid clears on an out transfer unless it is reloaded in the same cycle.
- The output register and the input are never overwritten while out_valid && !out_ready.
- P=0: the message is the single check nibble 0 with out_last=1.
- A new size may be accepted in IDLE while the previous check nibble is still pending on the output; accum and rem are reset by the size transfer. No data is accepted until the output frees.
- data_valid in IDLE or CHECK is ignored; data is held by the upstream source.

## Timing
- Reset (rst high at an edge):
  - State=IDLE; out_valid=0, out_data=0, out_last=0, accum=0, rem=0.
  - size_ready and data_ready are forced 0 while rst is high.
  - Reset mid-message discards all partial state; no check nibble is emitted for the aborted message.
- Size transfer edge -> DATA state at the next cycle. Earliest data transfer is 1 cycle after the size transfer.
- Data-to-out latency: 1 cycle. A nibble transferred at edge k is valid on out_data after edge k.
- Check nibble: loaded at the first edge in CHECK with the output free. With out_ready held high, this is 1 cycle after the last data transfer.
- Throughput with out_ready=1: 1 nibble/cycle. A P-nibble message costs P+2 cycles: size, P data, check.
- Backpressure: out_ready low holds out_data and out_last stable and drops data_ready the same cycle (combinational). There is no loss or duplication.
- Simultaneous out transfer and reload in the same edge: the reload wins and out_valid stays 1.
- rem wrap is impossible: DATA is exited at rem==1, and size 0 bypasses DATA.

## Test plan
- size=3, data 1,2,3, out_ready=1 -> out 1,2,3,6 on consecutive cycles; out_last only on 6.
- size=1, data F -> out F, then 1 (last).
- size=2, data 8,8 -> out 8,8,7 (last).
- size=0 -> the single out nibble 0 with out_last=1, one cycle after the size transfer; data_ready never asserted.
- size=3, data 1,2,3, out_ready low for 3 cycles after the first output:
  - out_data holds 1 and data_ready=0 throughout.
  - The final stream is still 1,2,3,6.
  - 255-nibble random payload: the output, fed through a reference Luhn mod-16 sum, gives 0.
- rst pulsed for 1 cycle after the first of 3 data transfers:
  - All outputs are 0 on the next cycle, and no out_last is seen.
  - A following size=2, data 8,8 yields 8,8,7.

Source files
------------

// File: rtl/luhnmod16_gen_if.sv
// Valid/ready streams of the Luhn mod-16 check-nibble generator:
// size words and payload nibbles in, payload plus check nibble out.
interface luhnmod16_gen_if #(
  parameter int SIZE_W = 8
);
  logic              size_valid;
  logic              size_ready;
  logic [SIZE_W-1:0] size;
  logic              data_valid;
  logic              data_ready;
  logic [3:0]        data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_data;
  logic              out_last;

  modport master (
    output size_valid, size, data_valid, data, out_ready,
    input  size_ready, data_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  size_valid, size, data_valid, data, out_ready,
    output size_ready, data_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/luhnmod16_gen.sv
// Luhn mod-16 check-nibble generator: forwards P payload nibbles and appends
// the nibble that makes the whole message sum to 0 mod 16.
module luhnmod16_gen #(
  parameter int SIZE_W = 8
) (
  input logic             clock,
  input logic             rst,
  luhnmod16_gen_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  state_t            state_q;
  logic [SIZE_W-1:0] rem_q;
  logic [3:0]        accum_q;
  logic [3:0]        out_data_q;
  logic              out_valid_q;
  logic              out_last_q;

  logic              out_free;
  logic              size_fire;
  logic              data_fire;
  logic [4:0]        dbl;
  logic [3:0]        weight_d;

  assign out_free = !out_valid_q || bus.out_ready;

  assign bus.size_ready = !rst && (state_q == IDLE);
  assign bus.data_ready = !rst && (state_q == DATA) && out_free;

  assign size_fire = bus.size_valid && bus.size_ready;
  assign data_fire = bus.data_valid && bus.data_ready;

  // Odd remaining count means this nibble is doubled; fold the carry back in.
  assign dbl      = {bus.data, 1'b0};
  assign weight_d = rem_q[0] ? (dbl[3:0] + {3'b000, dbl[4]}) : bus.data;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      accum_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (size_fire) begin
            rem_q   <= bus.size;
            accum_q <= '0;
            state_q <= (bus.size != '0) ? DATA : CHECK;
          end
        end
        DATA: begin
          if (data_fire) begin
            out_data_q  <= bus.data;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            accum_q     <= accum_q + weight_d;
            rem_q       <= rem_q - SIZE_W'(1);
            if (rem_q == SIZE_W'(1)) begin
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          if (out_free) begin
            out_data_q  <= 4'd0 - accum_q;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_luhnmod16_gen.sv
// Directed and random checks of luhnmod16_gen: stream contents, last flag,
// timing, backpressure, reset abort and a 255-nibble Luhn round trip.
module tb_luhnmod16_gen;
  localparam int SIZE_W = 8;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  luhnmod16_gen_if #(.SIZE_W(SIZE_W)) bus ();

  luhnmod16_gen #(.SIZE_W(SIZE_W)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    int          p;
    logic [31:0] d;   // first nibble in the top bits
    logic [35:0] e;   // expected stream, check nibble included
  } vec_t;

  vec_t vecs [8];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   size_edge = 0;
  logic [4:0] got_q [$];
  int         stamp_q [$];
  logic [3:0] pay [255];

  always @(posedge clock) cyc <= cyc + 1;

  // An out transfer seen here completes on the following rising edge.
  always @(negedge clock) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      got_q.push_back({bus.out_last, bus.out_data});
      stamp_q.push_back(cyc + 1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic send_size(input int p);
    bit ok = 1'b0;
    bus.size       = p[SIZE_W-1:0];
    bus.size_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (bus.size_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("size_accept", 32'(ok), 32'd1);
    size_edge = cyc + 1;
    @(posedge clock); #1;
    bus.size_valid = 1'b0;
  endtask

  task automatic send_data(input logic [3:0] d);
    bit ok = 1'b0;
    bus.data       = d;
    bus.data_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (bus.data_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("data_accept", 32'(ok), 32'd1);
    @(posedge clock); #1;
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_last(input string name);
    bit ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clock); #1;
      if (got_q.size() > 0 && got_q[$][4]) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done"}, 32'(ok), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic clear_q();
    got_q.delete();
    stamp_q.delete();
  endtask

  task automatic check_stream(input string name, input int p, input logic [35:0] e, input bit timed);
    check({name, "_count"}, 32'(got_q.size()), 32'(p + 1));
    for (int i = 0; i <= p && i < got_q.size(); i++) begin
      check($sformatf("%s_nib%0d", name, i), 32'(got_q[i][3:0]), 32'(e[35-4*i -: 4]));
      check($sformatf("%s_last%0d", name, i), 32'(got_q[i][4]), 32'(i == p));
      if (timed) check($sformatf("%s_cyc%0d", name, i), 32'(stamp_q[i] - size_edge), 32'(2 + i));
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    clear_q();
    @(posedge clock); #1;
    send_size(v.p);
    for (int i = 0; i < v.p; i++) send_data(v.d[31-4*i -: 4]);
    wait_last(name);
    check_stream(name, v.p, v.e, 1'b1);
  endtask

  initial begin
    int nlast;
    int sum;
    logic [4:0] dv;
    vecs[0] = '{3, 32'h1230_0000, 36'h1236_00000};
    vecs[1] = '{1, 32'hF000_0000, 36'hF100_00000};
    vecs[2] = '{2, 32'h8800_0000, 36'h8870_00000};
    vecs[3] = '{0, 32'h0000_0000, 36'h0000_00000};
    vecs[4] = '{4, 32'h9057_0000, 36'h9057_40000};
    vecs[5] = '{5, 32'hFFFF_F000, 36'hFFFF_F5000};
    vecs[6] = '{6, 32'h1234_5600, 36'h1234_56F00};
    vecs[7] = '{8, 32'h89AB_CDEF, 36'h89AB_CDEF0};

    bus.size_valid = 1'b0;
    bus.size       = '0;
    bus.data_valid = 1'b0;
    bus.data       = '0;
    bus.out_ready  = 1'b1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_size_ready", 32'(bus.size_ready), 32'd0);
    check("rst_data_ready", 32'(bus.data_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    check("init_out_data", 32'(bus.out_data), 32'd0);
    check("init_out_last", 32'(bus.out_last), 32'd0);
    check("init_size_ready", 32'(bus.size_ready), 32'd1);
    check("init_data_ready", 32'(bus.data_ready), 32'd0);

    for (int v = 0; v < 8; v++) run_vec($sformatf("vec%0d", v), vecs[v]);

    // Backpressure: out_ready low for 3 cycles once the first nibble is out.
    clear_q();
    @(posedge clock); #1;
    fork
      begin
        send_size(3);
        send_data(4'h1);
        send_data(4'h2);
        send_data(4'h3);
      end
      begin
        bit seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
          @(posedge clock); #1;
          if (bus.out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        check("bp_first_valid", 32'(seen), 32'd1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          check($sformatf("bp_hold_data%0d", k), 32'(bus.out_data), 32'h1);
          check($sformatf("bp_hold_last%0d", k), 32'(bus.out_last), 32'd0);
          check($sformatf("bp_data_ready%0d", k), 32'(bus.data_ready), 32'd0);
        end
        @(posedge clock); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_last("bp");
    check_stream("bp", 3, 36'h1236_00000, 1'b0);

    // Reset after the first of three data transfers aborts the message.
    clear_q();
    @(posedge clock); #1;
    send_size(3);
    send_data(4'h1);
    rst = 1'b1;
    @(negedge clock);
    check("mid_rst_size_ready", 32'(bus.size_ready), 32'd0);
    check("mid_rst_data_ready", 32'(bus.data_ready), 32'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_out_data", 32'(bus.out_data), 32'd0);
    check("post_rst_out_last", 32'(bus.out_last), 32'd0);
    repeat (5) @(negedge clock);
    nlast = 0;
    foreach (got_q[i]) if (got_q[i][4]) nlast++;
    check("post_rst_no_last", 32'(nlast), 32'd0);
    run_vec("post_rst", vecs[2]);

    // 255 random nibbles under random backpressure; Luhn sum of output must be 0.
    for (int i = 0; i < 255; i++) pay[i] = 4'($urandom_range(0, 15));
    clear_q();
    @(posedge clock); #1;
    fork
      begin
        send_size(255);
        for (int i = 0; i < 255; i++) send_data(pay[i]);
      end
      begin
        for (int t = 0; t < 3000; t++) begin
          @(posedge clock); #1;
          if (got_q.size() > 0 && got_q[$][4]) break;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_last("rand");
    check("rand_count", 32'(got_q.size()), 32'd256);
    if (got_q.size() >= 256) begin
      for (int i = 0; i < 255; i++)
        check($sformatf("rand_nib%0d", i), 32'(got_q[i][3:0]), 32'(pay[i]));
      nlast = 0;
      foreach (got_q[i]) if (got_q[i][4]) nlast++;
      check("rand_last_count", 32'(nlast), 32'd1);
      check("rand_last_pos", 32'(got_q[255][4]), 32'd1);
      sum = 0;
      for (int j = 0; j < 256; j++) begin
        if (j % 2 == 1) begin
          dv  = {got_q[255-j][3:0], 1'b0};
          sum = sum + int'(dv / 16) + int'(dv % 16);
        end else begin
          sum = sum + int'(got_q[255-j][3:0]);
        end
      end
      check("rand_luhn_sum", 32'(sum % 16), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
